// File: rtl/state_frame_tx_pkg.sv
// ============================================================================
// Module   : state_frame_tx_pkg
// Purpose  : Shared FSM encoding, frame constants and checksum helpers for
//            the status-frame UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package state_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } fsm_state_t;

    localparam int         FRAME_BYTES    = 4;
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    function automatic logic [7:0] checksum(input logic [7:0] hdr,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2);
        return hdr + b1 + b2;
    endfunction

    // Byte j of the frame built from a header and a captured status word.
    function automatic logic [7:0] frame_byte(input logic [7:0]  hdr,
                                              input logic [15:0] word,
                                              input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = hdr;
            2'd1:    b = word[15:8];
            2'd2:    b = word[7:0];
            default: b = checksum(hdr, word[15:8], word[7:0]);
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/state_frame_tx_if.sv
// ============================================================================
// Module   : state_frame_tx_if
// Purpose  : Trigger/status inputs and serial/handshake outputs of the
//            status-frame transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface state_frame_tx_if;
    logic        syn;
    logic        fault;
    logic [15:0] state;
    logic        tx;
    logic        busy;
    logic        frame_done;

    modport master (
        output syn, fault, state,
        input  tx, busy, frame_done
    );

    modport slave (
        input  syn, fault, state,
        output tx, busy, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/state_frame_tx_baud_tick.sv
// ============================================================================
// Module   : state_frame_tx_baud_tick
// Purpose  : Bit-period counter; tick is high on the last clock of each bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module state_frame_tx_baud_tick #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    output logic      tick
);
    localparam logic [15:0] C_LAST = 16'(BAUD_DIV - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == C_LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/state_frame_tx.sv
// ============================================================================
// Module   : state_frame_tx
// Purpose  : Sends HEADER, state[15:8], state[7:0], checksum as 8N1 UART
//            bytes on a rising edge of syn or fault.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module state_frame_tx
    import state_frame_tx_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434,
    parameter logic [7:0]  HEADER   = HEADER_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         rst,
    state_frame_tx_if.slave   bus
);
    localparam logic [1:0] C_LAST_BYTE = 2'(FRAME_BYTES - 1);

    fsm_state_t  fsm_q, fsm_d;
    logic        syn_dly_q, fault_dly_q;
    logic        pending_q, pending_d;
    logic [15:0] shadow_q, shadow_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    logic        w_req;
    logic        w_tick;
    logic        w_baud_clear;
    logic [7:0]  w_byte;

    assign w_req        = (bus.syn & ~syn_dly_q) | (bus.fault & ~fault_dly_q);
    assign w_baud_clear = (fsm_q == ST_IDLE) || (fsm_q == ST_LOAD);
    assign w_byte       = frame_byte(HEADER, shadow_q, byte_idx_q);

    state_frame_tx_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (w_baud_clear),
        .tick  (w_tick)
    );

    always_comb begin
        fsm_d        = fsm_q;
        pending_d    = pending_q;
        shadow_d     = shadow_q;
        byte_idx_d   = byte_idx_q;
        bit_cnt_d    = bit_cnt_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        tx_d         = 1'b1;

        case (fsm_q)
            ST_IDLE: begin
                if (w_req || pending_q) begin
                    fsm_d  = ST_LOAD;
                    busy_d = 1'b1;
                end
            end
            ST_LOAD: begin
                shadow_d   = bus.state;
                byte_idx_d = '0;
                bit_cnt_d  = '0;
                fsm_d      = ST_START;
            end
            ST_START: begin
                if (w_tick) begin
                    bit_cnt_d = '0;
                    fsm_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (bit_cnt_q == 3'd7) begin
                        fsm_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (byte_idx_q == C_LAST_BYTE) begin
                        fsm_d        = ST_IDLE;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        fsm_d      = ST_START;
                    end
                end
            end
            default: begin
                fsm_d  = ST_IDLE;
                busy_d = 1'b0;
            end
        endcase

        // Requests seen while a frame is underway collapse into one flag.
        if (fsm_d == ST_LOAD) begin
            pending_d = 1'b0;
        end else if (w_req && (fsm_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        // tx is registered, so it is derived from the state being entered.
        if (fsm_d == ST_START) begin
            tx_d = 1'b0;
        end else if (fsm_d == ST_DATA) begin
            tx_d = w_byte[bit_cnt_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q        <= ST_IDLE;
            syn_dly_q    <= 1'b0;
            fault_dly_q  <= 1'b0;
            pending_q    <= 1'b0;
            shadow_q     <= '0;
            byte_idx_q   <= '0;
            bit_cnt_q    <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            syn_dly_q    <= bus.syn;
            fault_dly_q  <= bus.fault;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            byte_idx_q   <= byte_idx_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_state_frame_tx.sv
// ============================================================================
// Module   : tb_state_frame_tx
// Purpose  : Self-checking bench; decodes the serial line and compares the
//            frames against bytes computed from the status word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_state_frame_tx;
    localparam int B   = 4;
    localparam int FL  = 40 * B;
    localparam int LOG = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic        tx_log    [LOG];
    logic        busy_log  [LOG];
    logic        done_log  [LOG];
    logic        syn_plan  [LOG];
    logic        fault_plan[LOG];
    logic [15:0] state_plan[LOG];

    state_frame_tx_if bus ();

    state_frame_tx #(
        .BAUD_DIV (B),
        .HEADER   (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected frame byte from the status word, by plain arithmetic.
    function automatic logic [7:0] exp_byte(input logic [15:0] st, input int j);
        int v;
        case (j)
            0:       v = 165;
            1:       v = int'(st) / 256;
            2:       v = int'(st) % 256;
            default: v = (165 + int'(st) / 256 + int'(st) % 256) % 256;
        endcase
        return 8'(v);
    endfunction

    function automatic logic [7:0] decode(input int s, input int j);
        logic [7:0] b;
        int         k;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            k = s + 10 * B * j + B * (1 + i) + B / 2;
            b[i] = (k >= 0 && k < LOG) ? tx_log[k] : 1'bx;
        end
        return b;
    endfunction

    function automatic int first_low(input int from, input int n);
        for (int i = from; i < n; i++) if (tx_log[i] === 1'b0) return i;
        return -1;
    endfunction

    function automatic int first_done(input int from, input int n);
        for (int i = from; i < n; i++) if (done_log[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_done(input int from, input int n);
        int c;
        c = 0;
        for (int i = from; i < n; i++) if (done_log[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic plan_clear(input logic [15:0] st, input logic flt);
        for (int i = 0; i < LOG; i++) begin
            syn_plan[i]   = 1'b0;
            fault_plan[i] = flt;
            state_plan[i] = st;
        end
    endtask

    task automatic plan_state_from(input int k, input logic [15:0] st);
        for (int i = k; i < LOG; i++) state_plan[i] = st;
    endtask

    task automatic plan_fault_from(input int k, input logic v);
        for (int i = k; i < LOG; i++) fault_plan[i] = v;
    endtask

    task automatic drive(input int k);
        bus.syn   = syn_plan[k];
        bus.fault = fault_plan[k];
        bus.state = state_plan[k];
    endtask

    // Entry at a falling edge; log[i] is sampled after the (i+1)th rising edge.
    task automatic run(input int n);
        drive(0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_log[i]   = bus.tx;
            busy_log[i] = bus.busy;
            done_log[i] = bus.frame_done;
            if (i + 1 < LOG) drive(i + 1);
        end
    endtask

    task automatic test_reset();
        bus.syn = 1'b0; bus.fault = 1'b0; bus.state = 16'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.frame_done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int s, d, hi;
        plan_clear(16'h1234, 1'b0);
        syn_plan[0] = 1'b1;
        run(200);
        s = first_low(0, 200);
        total++; if (s != 1) begin bad++; $display("FAIL basic_latency: got %0d want 1", s); end
        if (s < 0) s = 1;
        for (int j = 0; j < 4; j++) begin
            total++;
            if (decode(s, j) !== exp_byte(16'h1234, j)) begin
                bad++; $display("FAIL basic_byte%0d: got %h want %h", j, decode(s, j), exp_byte(16'h1234, j));
            end
        end
        d = first_done(0, 200);
        total++; if (d != s + FL) begin bad++; $display("FAIL basic_done_time: got %0d want %0d", d, s + FL); end
        hi = 0;
        for (int i = 0; i < s + FL; i++) if (busy_log[i] === 1'b1) hi++;
        total++; if (hi != s + FL) begin bad++; $display("FAIL basic_busy_high: got %0d want %0d", hi, s + FL); end
        total++; if (busy_log[s + FL] !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy_log[s + FL]); end
        total++; if (count_done(0, 200) != 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", count_done(0, 200)); end
    endtask

    task automatic test_fault();
        int s;
        plan_clear(16'h0080, 1'b0);
        plan_fault_from(0, 1'b1);
        run(500);
        s = first_low(0, 500);
        total++; if (s != 1) begin bad++; $display("FAIL fault_latency: got %0d want 1", s); end
        if (s < 0) s = 1;
        for (int j = 0; j < 4; j++) begin
            total++;
            if (decode(s, j) !== exp_byte(16'h0080, j)) begin
                bad++; $display("FAIL fault_byte%0d: got %h want %h", j, decode(s, j), exp_byte(16'h0080, j));
            end
        end
        total++; if (count_done(0, 500) != 1) begin bad++; $display("FAIL fault_repeat: got %0d frames want 1", count_done(0, 500)); end
    endtask

    task automatic test_coalesce();
        logic [15:0] s1, s2;
        int          s, t;
        s1 = 16'($urandom); s2 = 16'($urandom);
        plan_clear(s1, 1'b0);
        syn_plan[0] = 1'b1; syn_plan[20] = 1'b1; syn_plan[45] = 1'b1; syn_plan[90] = 1'b1;
        plan_fault_from(120, 1'b1);
        plan_state_from(100, s2);
        run(500);
        total++; if (count_done(0, 500) != 2) begin bad++; $display("FAIL coal_frames: got %0d want 2", count_done(0, 500)); end
        total++; if (first_done(0, 500) != 161) begin bad++; $display("FAIL coal_done1: got %0d want 161", first_done(0, 500)); end
        total++;
        if (busy_log[160] !== 1'b1 || busy_log[161] !== 1'b0 || busy_log[162] !== 1'b1) begin
            bad++; $display("FAIL coal_busy_gap: got %b%b%b want 101", busy_log[160], busy_log[161], busy_log[162]);
        end
        s = first_low(1, 500);
        for (int j = 0; j < 4; j++) begin
            total++;
            if (decode(s, j) !== exp_byte(s1, j)) begin
                bad++; $display("FAIL coal_f1_byte%0d: got %h want %h", j, decode(s, j), exp_byte(s1, j));
            end
        end
        t = first_low(162, 500);
        total++; if (t != 163) begin bad++; $display("FAIL coal_f2_start: got %0d want 163", t); end
        if (t < 0) t = 163;
        for (int j = 0; j < 4; j++) begin
            total++;
            if (decode(t, j) !== exp_byte(s2, j)) begin
                bad++; $display("FAIL coal_f2_byte%0d: got %h want %h", j, decode(t, j), exp_byte(s2, j));
            end
        end
        total++; if (first_done(162, 500) != 323) begin bad++; $display("FAIL coal_done2: got %0d want 323", first_done(162, 500)); end
    endtask

    task automatic test_snapshot();
        plan_clear(16'hFFFF, 1'b0);
        syn_plan[0] = 1'b1;
        plan_state_from(50, 16'h0000);
        run(200);
        for (int j = 0; j < 4; j++) begin
            total++;
            if (decode(1, j) !== exp_byte(16'hFFFF, j)) begin
                bad++; $display("FAIL snap_byte%0d: got %h want %h", j, decode(1, j), exp_byte(16'hFFFF, j));
            end
        end
    endtask

    task automatic test_done_edge();
        logic [15:0] st;
        st = 16'($urandom);
        plan_clear(st, 1'b0);
        syn_plan[0]   = 1'b1;
        syn_plan[162] = 1'b1;
        run(600);
        total++; if (count_done(0, 600) != 2) begin bad++; $display("FAIL doneedge_frames: got %0d want 2", count_done(0, 600)); end
        total++; if (first_low(162, 600) != 163) begin bad++; $display("FAIL doneedge_start: got %0d want 163", first_low(162, 600)); end
        total++;
        if (decode(163, 3) !== exp_byte(st, 3)) begin
            bad++; $display("FAIL doneedge_sum: got %h want %h", decode(163, 3), exp_byte(st, 3));
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] st;
        int          highs;
        plan_clear(16'hBEEF, 1'b0);
        syn_plan[0] = 1'b1;
        run(55);
        rst = 1'b1;
        #1;
        total++; if (bus.tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx: got %b want 1", bus.tx); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        plan_clear(16'hBEEF, 1'b0);
        run(300);
        highs = 0;
        for (int i = 0; i < 300; i++) if (tx_log[i] === 1'b1) highs++;
        total++; if (count_done(0, 300) != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", count_done(0, 300)); end
        total++; if (highs != 300) begin bad++; $display("FAIL rstmid_line_idle: got %0d want 300", highs); end
        st = 16'($urandom);
        plan_clear(st, 1'b0);
        syn_plan[0] = 1'b1;
        run(200);
        for (int j = 0; j < 4; j++) begin
            total++;
            if (decode(1, j) !== exp_byte(st, j)) begin
                bad++; $display("FAIL rstmid_after_byte%0d: got %h want %h", j, decode(1, j), exp_byte(st, j));
            end
        end
        total++; if (first_done(0, 200) != 161) begin bad++; $display("FAIL rstmid_after_done: got %0d want 161", first_done(0, 200)); end
    endtask

    task automatic test_idle();
        int errs;
        plan_clear(16'($urandom), 1'b0);
        run(1000);
        errs = 0;
        for (int i = 0; i < 1000; i++) if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL idle_line: got %0d non-idle cycles want 0", errs); end
    endtask

    task automatic test_random();
        logic [15:0] st;
        for (int n = 0; n < 5; n++) begin
            st = 16'($urandom);
            plan_clear(st, 1'b0);
            if ($urandom_range(1, 0) == 1) syn_plan[0] = 1'b1;
            else begin fault_plan[0] = 1'b1; fault_plan[1] = 1'b1; fault_plan[2] = 1'b1; end
            run(170);
            total++; if (first_low(0, 170) != 1) begin bad++; $display("FAIL rand%0d_latency: got %0d want 1", n, first_low(0, 170)); end
            for (int j = 0; j < 4; j++) begin
                total++;
                if (decode(1, j) !== exp_byte(st, j)) begin
                    bad++; $display("FAIL rand%0d_byte%0d: got %h want %h", n, j, decode(1, j), exp_byte(st, j));
                end
            end
            total++; if (first_done(0, 170) != 161) begin bad++; $display("FAIL rand%0d_done: got %0d want 161", n, first_done(0, 170)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fault();
        test_coalesce();
        test_snapshot();
        test_done_edge();
        test_reset_mid();
        test_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
